// File: rtl/wb_ram_pkg.sv
// Shared constants and FSM state type for the Wishbone single-port RAM controller.
package wb_ram_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Wishbone burst type identifiers
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        BURST = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-beat address for Wishbone incrementing bursts.
// Linear bursts wrap modulo 2^Aw; wrap bursts keep the bits above the
// wrap window and increment only inside it.
module wb_burst_addr_gen
    import wb_ram_pkg::*;
#(
    parameter int Aw = 10
) (
    input  logic [Aw-1:0] cur_addr_i,
    input  logic [1:0]    bte_i,
    output logic [Aw-1:0] nxt_addr_o
);

    logic [Aw-1:0] inc;
    logic [Aw-1:0] mask;

    // Merge the incremented low bits (inside the window) with the held upper bits
    always_comb begin
        inc = cur_addr_i + 1'b1;
        case (bte_i)
            BTE_WRAP4:  mask = Aw'(3);
            BTE_WRAP8:  mask = Aw'(7);
            BTE_WRAP16: mask = Aw'(15);
            default:    mask = '1;
        endcase
        nxt_addr_o = (cur_addr_i & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/wb_single_port_ram_ctrl.sv
// Wishbone B4 slave in front of a single-port RAM with a registered read
// address (one-cycle read latency). Classic accesses take two clocks.
// Optional macro WB_RAM_BURST_EN adds one-beat-per-cycle incrementing/wrapping
// read bursts and the reserved-cti error response.
module wb_single_port_ram_ctrl
    import wb_ram_pkg::*;
#(
    parameter int  Dw         = 32,
    parameter int  Aw         = 10,
    parameter      BYTE_WR_EN = "YES",
    parameter int  SELw       = Dw / 8,
    localparam int BYTE_ENw   = (BYTE_WR_EN == "YES") ? SELw : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Dw-1:0]       sa_dat_i,
    input  logic [Aw-1:0]       sa_addr_i,
    input  logic [SELw-1:0]     sa_sel_i,
    input  logic [2:0]          sa_cti_i,
    input  logic [1:0]          sa_bte_i,
    input  logic                sa_we_i,
    input  logic                sa_stb_i,
    input  logic                sa_cyc_i,
    output logic [Dw-1:0]       sa_dat_o,
    output logic                sa_ack_o,
    output logic                sa_err_o,
    output logic                sa_rty_o,
    output logic [Dw-1:0]       ram_data,
    output logic [Aw-1:0]       ram_addr,
    output logic [BYTE_ENw-1:0] ram_byteen,
    output logic                ram_we,
    input  logic [Dw-1:0]       ram_q
);

    logic      req;
    wb_state_e state_q, state_d;
    logic      ack, err, we;
    logic [Aw-1:0] addr;

    assign req      = sa_cyc_i & sa_stb_i;
    assign sa_dat_o = ram_q;
    assign sa_rty_o = 1'b0;
    assign ram_data = sa_dat_i;
    assign ram_addr = addr;
    assign ram_we   = we;
    assign sa_ack_o = ack;
    assign sa_err_o = err;

    generate
        if (BYTE_WR_EN == "YES") begin : g_byteen
            assign ram_byteen = sa_sel_i;
        end else begin : g_no_byteen
            logic unused_sel;
            assign unused_sel = ^sa_sel_i;
            assign ram_byteen = 1'b1;
        end
    endgenerate

`ifdef WB_RAM_BURST_EN
    logic [Aw-1:0] cur_addr_q, cur_addr_d;
    logic [Aw-1:0] nxt_addr;
    logic          err_q, err_d;
    logic          cti_rsv;

    assign cti_rsv = (sa_cti_i != CTI_CLASSIC) && (sa_cti_i != CTI_INC) &&
                     (sa_cti_i != CTI_END);

    wb_burst_addr_gen #(.Aw(Aw)) u_addr_gen (
        .cur_addr_i (cur_addr_q),
        .bte_i      (sa_bte_i),
        .nxt_addr_o (nxt_addr)
    );

    // State, current burst beat address and pending-error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            err_q      <= err_d;
        end
    end

    // Next state, RAM controls and bus responses
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        err_d      = err_q;
        ack        = 1'b0;
        err        = 1'b0;
        we         = 1'b0;
        addr       = sa_addr_i;
        case (state_q)
            IDLE: begin
                // reserved cycle types never touch the RAM
                we = req & sa_we_i & ~cti_rsv;
                if (req) begin
                    err_d = cti_rsv;
                    if (!sa_we_i && sa_cti_i == CTI_INC) begin
                        state_d    = BURST;
                        cur_addr_d = sa_addr_i;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                // a dropped cyc cancels the response
                ack     = sa_cyc_i & ~err_q;
                err     = sa_cyc_i & err_q;
                state_d = IDLE;
            end
            BURST: begin
                // cur_addr is the beat on the bus; prefetch the next one on ack,
                // re-present the current one during a wait state
                ack  = req;
                addr = cur_addr_q;
                if (req) begin
                    addr       = nxt_addr;
                    cur_addr_d = nxt_addr;
                    if (sa_cti_i == CTI_END) state_d = IDLE;
                end
                if (!sa_cyc_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic unused_burst;
    assign unused_burst = ^{sa_cti_i, sa_bte_i};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, RAM controls and bus responses (classic cycles only)
    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        err     = 1'b0;
        we      = 1'b0;
        addr    = sa_addr_i;
        case (state_q)
            IDLE: begin
                we = req & sa_we_i;
                if (req) state_d = ACK;
            end
            ACK: begin
                ack     = sa_cyc_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`endif

endmodule

// File: tb/tb_wb_single_port_ram_ctrl.sv
// Directed bench for wb_single_port_ram_ctrl with a behavioural single-port
// RAM (registered address, byte enables). Burst steps run when
// WB_RAM_BURST_EN is defined; otherwise classic fallback behaviour is checked.
module tb_wb_single_port_ram_ctrl;
    import wb_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sa_dat_i  = '0;
    logic [9:0]  sa_addr_i = '0;
    logic [3:0]  sa_sel_i  = '0;
    logic [2:0]  sa_cti_i  = '0;
    logic [1:0]  sa_bte_i  = '0;
    logic        sa_we_i = 1'b0, sa_stb_i = 1'b0, sa_cyc_i = 1'b0;
    logic [31:0] sa_dat_o;
    logic        sa_ack_o, sa_err_o, sa_rty_o;
    logic [31:0] ram_data;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_byteen;
    logic        ram_we;
    logic [31:0] ram_q;

    int checks = 0;
    int errors = 0;

    wb_single_port_ram_ctrl #(.Dw(32), .Aw(10), .BYTE_WR_EN("YES")) dut (
        .clk        (clk),
        .reset      (rst),
        .sa_dat_i   (sa_dat_i),
        .sa_addr_i  (sa_addr_i),
        .sa_sel_i   (sa_sel_i),
        .sa_cti_i   (sa_cti_i),
        .sa_bte_i   (sa_bte_i),
        .sa_we_i    (sa_we_i),
        .sa_stb_i   (sa_stb_i),
        .sa_cyc_i   (sa_cyc_i),
        .sa_dat_o   (sa_dat_o),
        .sa_ack_o   (sa_ack_o),
        .sa_err_o   (sa_err_o),
        .sa_rty_o   (sa_rty_o),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_byteen (ram_byteen),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // behavioural RAM: word = address preload, byte-enabled write, registered address
    logic [31:0] mem [0:1023];
    logic [9:0]  addr_r;
    logic        do_preload = 1'b0;
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
        end
        addr_r <= ram_addr;
    end
    assign ram_q = mem[addr_r];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic c, input logic s, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
        sa_cyc_i = c; sa_stb_i = s; sa_we_i = w; sa_addr_i = a;
        sa_dat_i = d; sa_sel_i = sl; sa_cti_i = ct; sa_bte_i = bt;
    endtask

    task automatic idle();
        bus(0, 0, 0, 10'h000, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    endtask

    initial begin
        // reset state
        bus(0, 0, 0, 10'h155, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
        do_preload = 1'b1;
        step();
        do_preload = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'b0, sa_ack_o}, 32'd0);
        chk("rst_err", {31'b0, sa_err_o}, 32'd0);
        chk("rst_rty", {31'b0, sa_rty_o}, 32'd0);
        chk("rst_we",  {31'b0, ram_we},   32'd0);
        chk("rst_addr", {22'b0, ram_addr}, 32'h155);
        step();
        rst = 1'b0;
        idle();

        // classic write 0x010 <= DEADBEEF
        step();
        bus(1, 1, 1, 10'h010, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk);
        chk("wr_we_c0",  {31'b0, ram_we},   32'd1);
        chk("wr_ack_c0", {31'b0, sa_ack_o}, 32'd0);
        chk("wr_addr",   {22'b0, ram_addr}, 32'h010);
        chk("wr_byteen", {28'b0, ram_byteen}, 32'hF);
        step();
        @(negedge clk);
        chk("wr_ack_c1", {31'b0, sa_ack_o}, 32'd1);
        chk("wr_we_c1",  {31'b0, ram_we},   32'd0);
        step();
        idle();

        // classic read 0x010
        step();
        bus(1, 1, 0, 10'h010, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk);
        chk("rd_ack_c0", {31'b0, sa_ack_o}, 32'd0);
        step();
        @(negedge clk);
        chk("rd_ack_c1", {31'b0, sa_ack_o}, 32'd1);
        chk("rd_dat",    sa_dat_o, 32'hDEADBEEF);
        step();
        idle();

        // byte write lane 1, then read back
        step();
        bus(1, 1, 1, 10'h010, 32'h0000AB00, 4'b0010, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk);
        chk("bw_byteen", {28'b0, ram_byteen}, 32'h2);
        step();
        @(negedge clk);
        chk("bw_ack", {31'b0, sa_ack_o}, 32'd1);
        step();
        bus(1, 1, 0, 10'h010, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        step();
        @(negedge clk);
        chk("bw_rd_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("bw_rd_dat", sa_dat_o, 32'hDEADABEF);
        step();
        idle();

`ifdef WB_RAM_BURST_EN
        // linear 4-beat burst from 0x3FE across the top of the address space
        step();
        bus(1, 1, 0, 10'h3FE, 32'h0, 4'hF, CTI_INC, BTE_LINEAR);
        @(negedge clk);
        chk("lin_c0_ack",  {31'b0, sa_ack_o}, 32'd0);
        chk("lin_c0_addr", {22'b0, ram_addr}, 32'h3FE);
        step(); @(negedge clk);
        chk("lin_b1_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("lin_b1_dat", sa_dat_o, 32'h3FE);
        chk("lin_b1_addr", {22'b0, ram_addr}, 32'h3FF);
        step(); @(negedge clk);
        chk("lin_b2_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("lin_b2_dat", sa_dat_o, 32'h3FF);
        step(); @(negedge clk);
        chk("lin_b3_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("lin_b3_dat", sa_dat_o, 32'h000);
        step();
        sa_cti_i = CTI_END;
        @(negedge clk);
        chk("lin_b4_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("lin_b4_dat", sa_dat_o, 32'h001);
        step(); @(negedge clk);
        chk("lin_after_ack", {31'b0, sa_ack_o}, 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("lin_cancel_ack", {31'b0, sa_ack_o}, 32'd0);

        // wrap4 burst from 0x006 with one wait state after beat 2
        step();
        bus(1, 1, 0, 10'h006, 32'h0, 4'hF, CTI_INC, BTE_WRAP4);
        step(); @(negedge clk);
        chk("w4_b1_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("w4_b1_dat", sa_dat_o, 32'h006);
        step(); @(negedge clk);
        chk("w4_b2_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("w4_b2_dat", sa_dat_o, 32'h007);
        step();
        sa_stb_i = 1'b0;
        @(negedge clk);
        chk("w4_gap_ack",  {31'b0, sa_ack_o}, 32'd0);
        chk("w4_gap_addr", {22'b0, ram_addr}, 32'h004);
        step();
        sa_stb_i = 1'b1;
        @(negedge clk);
        chk("w4_b3_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("w4_b3_dat", sa_dat_o, 32'h004);
        step();
        sa_cti_i = CTI_END;
        @(negedge clk);
        chk("w4_b4_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("w4_b4_dat", sa_dat_o, 32'h005);
        step();
        idle();

        // reserved cti on a write: err pulse, no ack, RAM untouched
        step();
        bus(1, 1, 1, 10'h020, 32'h12345678, 4'hF, 3'b011, BTE_LINEAR);
        @(negedge clk);
        chk("rsv_we", {31'b0, ram_we}, 32'd0);
        step(); @(negedge clk);
        chk("rsv_err", {31'b0, sa_err_o}, 32'd1);
        chk("rsv_ack", {31'b0, sa_ack_o}, 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("rsv_err_once", {31'b0, sa_err_o}, 32'd0);
        step();
        bus(1, 1, 0, 10'h020, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        step(); @(negedge clk);
        chk("rsv_rd_dat", sa_dat_o, 32'h00000020);
        step();
        idle();

        // reset during a burst after beat 2
        step();
        bus(1, 1, 0, 10'h100, 32'h0, 4'hF, CTI_INC, BTE_LINEAR);
        step(); @(negedge clk);
        chk("rb_b1_dat", sa_dat_o, 32'h100);
        step(); @(negedge clk);
        chk("rb_b2_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("rb_b2_dat", sa_dat_o, 32'h101);
        step();
        rst = 1'b1;
        #1;
        chk("rb_ack",   {31'b0, sa_ack_o}, 32'd0);
        chk("rb_err",   {31'b0, sa_err_o}, 32'd0);
        chk("rb_state", 32'(dut.state_q), 32'(IDLE));
        step();
        idle();
        rst = 1'b0;
`else
        // without burst support an incrementing read is a classic single access
        step();
        bus(1, 1, 0, 10'h3FE, 32'h0, 4'hF, CTI_INC, BTE_LINEAR);
        step(); @(negedge clk);
        chk("nb_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("nb_dat", sa_dat_o, 32'h3FE);
        step(); @(negedge clk);
        chk("nb_ack_c2", {31'b0, sa_ack_o}, 32'd0);
        step();
        idle();

        // reserved cti is ignored: normal write, no err
        step();
        bus(1, 1, 1, 10'h020, 32'h12345678, 4'hF, 3'b011, BTE_LINEAR);
        @(negedge clk);
        chk("nb_rsv_we", {31'b0, ram_we}, 32'd1);
        step(); @(negedge clk);
        chk("nb_rsv_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("nb_rsv_err", {31'b0, sa_err_o}, 32'd0);
        step();
        idle();
`endif

        // classic read after everything above
        step();
        bus(1, 1, 0, 10'h010, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        step(); @(negedge clk);
        chk("fin_ack", {31'b0, sa_ack_o}, 32'd1);
        chk("fin_dat", sa_dat_o, 32'hDEADABEF);
        step();
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
